// File: rtl/odyssey_video_pkg.sv
// Shared types and per-mode vertical timing for the Odyssey raster generator.
package odyssey_video_pkg;

    typedef enum logic {
        MODE_NTSC = 1'b0,
        MODE_PAL  = 1'b1
    } mode_e;

    localparam int NTSC_V_TOTAL  = 262;
    localparam int NTSC_V_ACTIVE = 240;
    localparam int NTSC_VS_START = 245;
    localparam int PAL_V_TOTAL   = 312;
    localparam int PAL_V_ACTIVE  = 288;
    localparam int PAL_VS_START  = 295;

    function automatic int v_total(mode_e m);
        return (m == MODE_PAL) ? PAL_V_TOTAL : NTSC_V_TOTAL;
    endfunction

    function automatic int v_active(mode_e m);
        return (m == MODE_PAL) ? PAL_V_ACTIVE : NTSC_V_ACTIVE;
    endfunction

    function automatic int vs_start(mode_e m);
        return (m == MODE_PAL) ? PAL_VS_START : NTSC_VS_START;
    endfunction

endpackage

// File: rtl/odyssey_ce_div.sv
// Clock-enable divider: tick is the early (combinational) strobe, ce its registered copy.
module odyssey_ce_div #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic ce
);
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          ce_q, ce_d;

    always_comb begin
        tick  = (div_q == DW'(DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
        ce_d  = tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/odyssey_video_timing.sv
// Parametrised raster timing generator; NTSC/PAL mode is latched only at the frame boundary.
module odyssey_video_timing
    import odyssey_video_pkg::*;
#(
    parameter int CE_DIV   = 8,
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int FW       = 8,
    parameter int H_TOTAL  = 341,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 280,
    parameter int HS_LEN   = 25,
    parameter int VS_LEN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pal,
    output logic          ce_pix,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          new_frame,
    output logic          mode_pal,
    output logic [FW-1:0] frame_cnt
);
    localparam int CW = ((HW > VW) ? HW : VW) + 1;

    if (H_TOTAL > (1 << HW)) begin : g_bad_htotal
        $error("H_TOTAL does not fit in hcnt");
    end
    if (PAL_V_TOTAL > (1 << VW)) begin : g_bad_vtotal
        $error("PAL V_TOTAL does not fit in vcnt");
    end
    if (HS_START + HS_LEN > H_TOTAL) begin : g_bad_hsync
        $error("hsync extends past end of line");
    end
    if (CE_DIV < 2) begin : g_bad_div
        $error("CE_DIV must be at least 2");
    end

    logic          tick;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    mode_e         mode_q, mode_d;
    logic          hblank_q, hblank_d, vblank_q, vblank_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          de_q, de_d, new_frame_q, new_frame_d;
    logic [CW-1:0] hx_d, vx_d;
    logic          h_last, v_last;

    odyssey_ce_div #(.DIV(CE_DIV)) u_ce_div (
        .clk  (clk),
        .rst  (reset),
        .tick (tick),
        .ce   (ce_pix)
    );

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        new_frame_d = 1'b0;
        h_last      = (CW'(hcnt_q) == CW'(H_TOTAL - 1));
        v_last      = (CW'(vcnt_q) == CW'(v_total(mode_q) - 1));
        if (tick) begin
            if (h_last) begin
                hcnt_d = '0;
                if (v_last) begin
                    vcnt_d      = '0;
                    mode_d      = pal ? MODE_PAL : MODE_NTSC;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    new_frame_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Decode from next-state values so sync/blank land on the same clk as the counters.
    always_comb begin
        hx_d     = CW'(hcnt_d);
        vx_d     = CW'(vcnt_d);
        hblank_d = (hx_d >= CW'(H_ACTIVE));
        vblank_d = (vx_d >= CW'(v_active(mode_d)));
        hsync_d  = (hx_d >= CW'(HS_START)) && (hx_d < CW'(HS_START + HS_LEN));
        vsync_d  = (vx_d >= CW'(vs_start(mode_d))) && (vx_d < CW'(vs_start(mode_d) + VS_LEN));
        de_d     = ~(hblank_d | vblank_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            mode_q      <= MODE_NTSC;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b1;
            new_frame_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign frame_cnt = frame_cnt_q;
    assign mode_pal  = (mode_q == MODE_PAL);
    assign hblank    = hblank_q;
    assign vblank    = vblank_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign new_frame = new_frame_q;

endmodule

// File: tb/tb_odyssey_video_timing.sv
// Scoreboard bench: u_a runs the default raster, u_b a short-line raster for whole-frame checks.
module tb_odyssey_video_timing;

    typedef struct {
        int   clk;
        int   h;
        int   v;
        logic hs;
        logic hb;
        logic vb;
        logic de;
    } pix_t;

    typedef struct {
        int   kind;
        int   clk;
        int   h;
        int   v;
        logic mode;
        int   fc;
    } ev_t;

    localparam int EV_FRAME = 0;
    localparam int EV_VB    = 1;
    localparam int EV_VS    = 2;
    localparam int EV_VSF   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pal = 1'b0;
    always #5 clk = ~clk;

    logic       a_ce, a_hb, a_vb, a_hs, a_vs, a_de, a_nf, a_mode;
    logic [8:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_ce, b_hb, b_vb, b_hs, b_vs, b_de, b_nf, b_mode;
    logic [8:0] b_h, b_v;
    logic [7:0] b_fc;

    odyssey_video_timing u_a (
        .clk(clk), .reset(rst), .pal(pal), .ce_pix(a_ce), .hcnt(a_h), .vcnt(a_v),
        .hblank(a_hb), .vblank(a_vb), .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .new_frame(a_nf), .mode_pal(a_mode), .frame_cnt(a_fc)
    );

    odyssey_video_timing #(
        .CE_DIV(4), .H_TOTAL(16), .H_ACTIVE(10), .HS_START(12), .HS_LEN(2)
    ) u_b (
        .clk(clk), .reset(rst), .pal(pal), .ce_pix(b_ce), .hcnt(b_h), .vcnt(b_v),
        .hblank(b_hb), .vblank(b_vb), .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .new_frame(b_nf), .mode_pal(b_mode), .frame_cnt(b_fc)
    );

    int   checks = 0;
    int   failures = 0;
    int   clk_cnt;
    pix_t pix_q[$];
    ev_t  ev_q[$];
    logic b_mon_en = 1'b1;
    logic b_vs_prev, b_vb_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) clk_cnt <= 0;
        else     clk_cnt <= clk_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // flags packed as {ce,hblank,vblank,hsync,vsync,de,new_frame,mode_pal}
    task automatic chk_reset(input string tag);
        chk({tag, "_a_cnt"}, int'(a_h) + int'(a_v) + int'(a_fc), 0);
        chk({tag, "_a_flags"}, int'({a_ce, a_hb, a_vb, a_hs, a_vs, a_de, a_nf, a_mode}), 4);
        chk({tag, "_b_cnt"}, int'(b_h) + int'(b_v) + int'(b_fc), 0);
        chk({tag, "_b_flags"}, int'({b_ce, b_hb, b_vb, b_hs, b_vs, b_de, b_nf, b_mode}), 4);
    endtask

    task automatic got_event(input int kind);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL b_event_unexpected kind=%0d clk=%0d vcnt=%0d", kind, clk_cnt, b_v);
        end else begin
            e = ev_q.pop_front();
            if (kind != e.kind || clk_cnt != e.clk || int'(b_h) != e.h || int'(b_v) != e.v ||
                b_mode != e.mode || int'(b_fc) != e.fc) begin
                failures++;
                $display("FAIL b_event actual kind=%0d clk=%0d h=%0d v=%0d mode=%0d fc=%0d required kind=%0d clk=%0d h=%0d v=%0d mode=%0d fc=%0d",
                         kind, clk_cnt, b_h, b_v, b_mode, b_fc, e.kind, e.clk, e.h, e.v, e.mode, e.fc);
            end
        end
    endtask

    // Pixel monitor for u_a: every ce_pix is matched against the next expected pixel.
    always @(negedge clk) begin
        pix_t e;
        if (!rst && a_ce && pix_q.size() > 0) begin
            e = pix_q.pop_front();
            checks++;
            if (clk_cnt != e.clk || int'(a_h) != e.h || int'(a_v) != e.v || a_hs != e.hs ||
                a_hb != e.hb || a_vb != e.vb || a_de != e.de) begin
                failures++;
                $display("FAIL a_pixel actual clk=%0d h=%0d v=%0d hs=%0d hb=%0d vb=%0d de=%0d required clk=%0d h=%0d v=%0d hs=%0d hb=%0d vb=%0d de=%0d",
                         clk_cnt, a_h, a_v, a_hs, a_hb, a_vb, a_de, e.clk, e.h, e.v, e.hs, e.hb, e.vb, e.de);
            end
        end
    end

    // Event monitor for u_b: frame strobes and vblank/vsync edges.
    always @(negedge clk) begin
        if (rst) begin
            b_vs_prev <= 1'b0;
            b_vb_prev <= 1'b0;
        end else begin
            if (b_mon_en) begin
                if (b_nf)               got_event(EV_FRAME);
                if (b_vb && !b_vb_prev) got_event(EV_VB);
                if (b_vs && !b_vs_prev) got_event(EV_VS);
                if (!b_vs && b_vs_prev) got_event(EV_VSF);
            end
            b_vs_prev <= b_vs;
            b_vb_prev <= b_vb;
        end
    end

    initial begin
        pix_t p;
        ev_t  e;
        int   base, lines, va, vs, fc_in;
        logic m_in, m_next;
        int   cnt, bad, last, n;

        // u_a: first 700 pixels of the default raster, 8 clks each
        for (int i = 1; i <= 700; i++) begin
            p.clk = 8 * i;
            p.h   = i % 341;
            p.v   = i / 341;
            p.hs  = (p.h >= 280) && (p.h < 305);
            p.hb  = (p.h >= 256);
            p.vb  = 1'b0;
            p.de  = !p.hb;
            pix_q.push_back(p);
        end

        // u_b: 16 px/line, 4 clks/px; frames NTSC, NTSC (pal raised mid-frame), PAL
        for (int f = 0; f < 3; f++) begin
            case (f)
                0:       begin base = 0;    lines = 262; va = 240; vs = 245; m_in = 1'b0; m_next = 1'b0; end
                1:       begin base = 4192; lines = 262; va = 240; vs = 245; m_in = 1'b0; m_next = 1'b1; end
                default: begin base = 8384; lines = 312; va = 288; vs = 295; m_in = 1'b1; m_next = 1'b1; end
            endcase
            fc_in = f;
            e.h = 0;
            e.kind = EV_VB;  e.v = va;     e.clk = (base + va * 16) * 4;       e.mode = m_in;   e.fc = fc_in;
            ev_q.push_back(e);
            e.kind = EV_VS;  e.v = vs;     e.clk = (base + vs * 16) * 4;       e.mode = m_in;   e.fc = fc_in;
            ev_q.push_back(e);
            e.kind = EV_VSF; e.v = vs + 3; e.clk = (base + (vs + 3) * 16) * 4; e.mode = m_in;   e.fc = fc_in;
            ev_q.push_back(e);
            e.kind = EV_FRAME; e.v = 0;    e.clk = (base + lines * 16) * 4;    e.mode = m_next; e.fc = f + 1;
            ev_q.push_back(e);
        end

        repeat (10) @(posedge clk);
        #1 chk_reset("in_reset");
        @(negedge clk);
        rst = 1'b0;
        #1 chk_reset("release");

        cnt = 0; bad = 0; last = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_ce) begin
                cnt++;
                if (clk_cnt - last != 4) bad++;
                last = clk_cnt;
            end
        end
        chk("b_ce_pulses", cnt, 25);
        chk("b_ce_spacing_errs", bad, 0);

        n = 0;
        while (pix_q.size() > 0 && n < 6000) begin @(negedge clk); n++; end
        chk("a_pixels_left", pix_q.size(), 0);

        n = 0;
        while (b_fc != 8'd1 && n < 20000) begin @(negedge clk); n++; end
        chk("b_reach_frame1", int'(b_fc), 1);
        n = 0;
        while (b_v != 9'd100 && n < 10000) begin @(negedge clk); n++; end
        chk("b_reach_line100", int'(b_v), 100);
        pal = 1'b1;

        n = 0;
        while (ev_q.size() > 0 && n < 45000) begin @(negedge clk); n++; end
        chk("b_events_left", ev_q.size(), 0);

        n = 0;
        while (b_v != 9'd150 && n < 15000) begin @(negedge clk); n++; end
        chk("b_pre_reset_line", int'(b_v), 150);
        chk("b_pre_reset_fc", int'(b_fc), 3);
        chk("b_pre_reset_mode", int'(b_mode), 1);
        b_mon_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset("async_clear");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_reset("re_release");
        repeat (4) @(negedge clk);
        chk("b_restart_ce", int'(b_ce), 1);
        chk("b_restart_hv", int'(b_h) * 1000 + int'(b_v), 1000);
        chk("b_restart_mode", int'(b_mode), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
